// File: rtl/reaction_meter.sv
// Reaction-time meter: times 1 kHz ticks from light-on to the stop button.
// Define REACTION_BEST_EN to keep the session's best (minimum) valid time.
module reaction_meter (
  input  logic        clk1k,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        light,
  input  logic        stop,
  output logic [11:0] elapsed,
  output logic        valid,
  output logic        false_start,
  output logic        overflow,
  output logic        busy,
  output logic [11:0] best,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_TIMING = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  logic [1:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] elapsed_q, elapsed_d;
  logic        valid_q, valid_d;
  logic        false_start_q, false_start_d;
  logic        overflow_q, overflow_d;
  logic        good_stop;

  // Set on exactly the edge that latches a valid measurement.
  assign good_stop = !arm && (state_q == ST_TIMING) && stop;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    elapsed_d     = elapsed_q;
    valid_d       = valid_q;
    false_start_d = false_start_q;
    overflow_d    = overflow_q;

    if (arm) begin
      state_d       = ST_ARMED;
      cnt_d         = '0;
      elapsed_d     = '0;
      valid_d       = 1'b0;
      false_start_d = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          // Stop wins over light, so a simultaneous press is a false start.
          if (stop) begin
            false_start_d = 1'b1;
            elapsed_d     = '0;
            state_d       = ST_DONE;
          end else if (light) begin
            cnt_d   = '0;
            state_d = ST_TIMING;
          end
        end
        ST_TIMING: begin
          if (stop) begin
            elapsed_d = cnt_q;
            valid_d   = 1'b1;
            state_d   = ST_DONE;
          end else if (cnt_q == CNT_MAX) begin
            elapsed_d  = CNT_MAX;
            overflow_d = 1'b1;
            valid_d    = 1'b0;
            state_d    = ST_DONE;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk1k) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      elapsed_q     <= '0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      elapsed_q     <= elapsed_d;
      valid_q       <= valid_d;
      false_start_q <= false_start_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef REACTION_BEST_EN
  logic [11:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (good_stop && (cnt_q < best_q)) begin
      best_d = cnt_q;
    end
  end

  always_ff @(posedge clk1k) begin
    if (!rst_n) begin
      best_q <= CNT_MAX;
    end else begin
      best_q <= best_d;
    end
  end

  assign best = best_q;
`else
  logic unused_good_stop;
  assign unused_good_stop = good_stop;
  assign best = CNT_MAX;
`endif

  assign elapsed     = elapsed_q;
  assign valid       = valid_q;
  assign false_start = false_start_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q == ST_ARMED) || (state_q == ST_TIMING);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_reaction_meter.sv
// Bench for reaction_meter: per-edge vector table plus multi-cycle sequences.
module tb_reaction_meter;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_TIMING = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic        clk1k;
  logic        rst_n;
  logic        arm;
  logic        light;
  logic        stop;
  logic [11:0] elapsed;
  logic        valid;
  logic        false_start;
  logic        overflow;
  logic        busy;
  logic [11:0] best;
  logic [1:0]  state_dbg;

  int checks;
  int failures;

  reaction_meter dut (
    .clk1k      (clk1k),
    .rst_n      (rst_n),
    .arm        (arm),
    .light      (light),
    .stop       (stop),
    .elapsed    (elapsed),
    .valid      (valid),
    .false_start(false_start),
    .overflow   (overflow),
    .busy       (busy),
    .best       (best),
    .state_dbg  (state_dbg)
  );

  // Clock and reset defaults
  initial clk1k = 1'b0;
  always #5 clk1k = ~clk1k;

  typedef struct {
    logic        rst_n;
    logic        arm;
    logic        light;
    logic        stop;
    logic [11:0] e_elapsed;
    logic        e_valid;
    logic        e_fs;
    logic        e_ov;
    logic        e_busy;
    logic [11:0] e_best_en;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [11:0] best_exp(input logic [11:0] when_enabled);
`ifdef REACTION_BEST_EN
    return when_enabled;
`else
    return 12'hFFF;
`endif
  endfunction

  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] e_elapsed, input logic e_valid,
                           input logic e_fs, input logic e_ov, input logic e_busy,
                           input logic [11:0] e_best, input logic [1:0] e_state);
    cmp({tag, ".elapsed"}, elapsed, e_elapsed);
    cmp({tag, ".valid"}, {11'd0, valid}, {11'd0, e_valid});
    cmp({tag, ".false_start"}, {11'd0, false_start}, {11'd0, e_fs});
    cmp({tag, ".overflow"}, {11'd0, overflow}, {11'd0, e_ov});
    cmp({tag, ".busy"}, {11'd0, busy}, {11'd0, e_busy});
    cmp({tag, ".best"}, best, e_best);
    cmp({tag, ".state"}, {10'd0, state_dbg}, {10'd0, e_state});
  endtask

  // Driver: apply inputs, wait one edge, settle.
  task automatic drive(input logic r, input logic a, input logic l, input logic s);
    rst_n = r; arm = a; light = l; stop = s;
    @(posedge clk1k);
    #1;
  endtask

  // Arm, show light at E0, press stop at E0+n; expects elapsed = n-1.
  task automatic run_round(input int n, input logic [11:0] exp_best_en, input string tag);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 0);
    for (int i = 1; i < n; i++) drive(1, 0, 1, 0);
    cmp({tag, ".busy_before_stop"}, {11'd0, busy}, 12'd1);
    drive(1, 0, 1, 1);
    check_all(tag, 12'(n - 1), 1, 0, 0, 0, best_exp(exp_best_en), S_DONE);
  endtask

  task automatic run_false_start(input logic [11:0] exp_best_en, input string tag);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    check_all(tag, 0, 0, 1, 0, 0, best_exp(exp_best_en), S_DONE);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; arm = 1'b0; light = 1'b0; stop = 1'b0;

    //            rst arm lit stp  elapsed v fs ov busy best   state
    vecs[0]  = '{0, 0, 0, 0, 12'd0,  0, 0, 0, 0, 12'hFFF, S_IDLE};
    vecs[1]  = '{0, 0, 0, 0, 12'd0,  0, 0, 0, 0, 12'hFFF, S_IDLE};
    vecs[2]  = '{1, 0, 1, 1, 12'd0,  0, 0, 0, 0, 12'hFFF, S_IDLE};
    vecs[3]  = '{1, 1, 0, 0, 12'd0,  0, 0, 0, 1, 12'hFFF, S_ARMED};
    vecs[4]  = '{1, 1, 1, 0, 12'd0,  0, 0, 0, 1, 12'hFFF, S_ARMED};
    vecs[5]  = '{1, 0, 1, 0, 12'd0,  0, 0, 0, 1, 12'hFFF, S_TIMING};
    vecs[6]  = '{1, 0, 0, 0, 12'd0,  0, 0, 0, 1, 12'hFFF, S_TIMING};
    vecs[7]  = '{1, 0, 0, 0, 12'd0,  0, 0, 0, 1, 12'hFFF, S_TIMING};
    vecs[8]  = '{1, 0, 0, 1, 12'd2,  1, 0, 0, 0, 12'd2,   S_DONE};
    vecs[9]  = '{1, 0, 1, 1, 12'd2,  1, 0, 0, 0, 12'd2,   S_DONE};
    vecs[10] = '{1, 1, 0, 0, 12'd0,  0, 0, 0, 1, 12'd2,   S_ARMED};
    vecs[11] = '{1, 0, 0, 1, 12'd0,  0, 1, 0, 0, 12'd2,   S_DONE};
    vecs[12] = '{1, 1, 0, 0, 12'd0,  0, 0, 0, 1, 12'd2,   S_ARMED};
    vecs[13] = '{1, 0, 1, 1, 12'd0,  0, 1, 0, 0, 12'd2,   S_DONE};
    vecs[14] = '{1, 1, 0, 0, 12'd0,  0, 0, 0, 1, 12'd2,   S_ARMED};
    vecs[15] = '{1, 0, 1, 0, 12'd0,  0, 0, 0, 1, 12'd2,   S_TIMING};
    vecs[16] = '{1, 0, 0, 1, 12'd0,  1, 0, 0, 0, 12'd0,   S_DONE};
    vecs[17] = '{0, 1, 1, 0, 12'd0,  0, 0, 0, 0, 12'hFFF, S_IDLE};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst_n, vecs[i].arm, vecs[i].light, vecs[i].stop);
      check_all($sformatf("vec%0d", i), vecs[i].e_elapsed, vecs[i].e_valid, vecs[i].e_fs,
                vecs[i].e_ov, vecs[i].e_busy, best_exp(vecs[i].e_best_en), vecs[i].e_state);
    end

    // 250 ms round from a fresh reset.
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    run_round(251, 12'd250, "r250");

    // Overflow: light with no stop for 4096 edges.
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    for (int i = 1; i < 4096; i++) drive(1, 0, 1, 0);
    check_all("ovf_pre", 0, 0, 0, 0, 1, 12'hFFF, S_TIMING);
    drive(1, 0, 1, 0);
    check_all("ovf", 12'hFFF, 0, 0, 1, 0, 12'hFFF, S_DONE);
    drive(1, 0, 1, 1);
    check_all("ovf_hold", 12'hFFF, 0, 0, 1, 0, 12'hFFF, S_DONE);

    // Best tracking over several rounds.
    drive(0, 0, 0, 0);
    run_round(301, 12'd300, "r300");
    run_round(181, 12'd180, "r180");
    run_round(221, 12'd180, "r220");
    run_false_start(12'd180, "fs_best");

    // Re-arm mid-timing clears flags and counter, keeps best.
    drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 0, 1, 0);
    drive(1, 1, 1, 0);
    check_all("rearm", 0, 0, 0, 0, 1, best_exp(12'd180), S_ARMED);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 1);
    check_all("rearm_round", 12'd2, 1, 0, 0, 0, best_exp(12'd2), S_DONE);

    // Reset wins over arm while timing.
    drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 1, 1, 0);
    check_all("rst_mid", 0, 0, 0, 0, 0, 12'hFFF, S_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
